// File: rtl/output_drain_pkg.sv
// Shared types, widths and the round/saturate helper for output drain paths.
package output_drain_pkg;

    localparam int unsigned I_WIDTH         = 8;
    localparam int unsigned F_WIDTH         = 8;
    localparam int unsigned AW_D            = I_WIDTH + F_WIDTH;
    localparam int unsigned BRAM_ADDR_WIDTH = 11;
    localparam int unsigned OUT_WIDTH       = 8;
    localparam int unsigned SHIFT_WIDTH     = 4;
    localparam int unsigned EXT_WIDTH       = AW_D + 1;

    // Saturation bounds expressed at the extended accumulator width.
    localparam logic signed [EXT_WIDTH-1:0] SAT_MAX = EXT_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [EXT_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_state_t;

    // Optional ReLU, round-half-up arithmetic right shift, saturate to OUT_WIDTH.
    function automatic logic signed [OUT_WIDTH-1:0] round_sat(
        input logic signed [AW_D-1:0]        acc,
        input logic        [SHIFT_WIDTH-1:0] shift,
        input logic                          relu
    );
        logic signed [AW_D-1:0]      x;
        logic signed [EXT_WIDTH-1:0] ext;
        logic signed [EXT_WIDTH-1:0] rnd;
        logic signed [EXT_WIDTH-1:0] shifted;
        x   = (relu && (acc < 0)) ? '0 : acc;
        ext = {x[AW_D-1], x};
        rnd = (shift != '0) ? (EXT_WIDTH'(1) << (shift - SHIFT_WIDTH'(1))) : '0;
        // Extra headroom bit keeps ext + rnd from wrapping; large shifts fill with sign.
        shifted = (ext + rnd) >>> shift;
        if (shifted > SAT_MAX) begin
            return OUT_WIDTH'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            return OUT_WIDTH'(SAT_MIN);
        end
        return OUT_WIDTH'(shifted);
    endfunction

endpackage

// File: rtl/output_drain_skid.sv
// Two-entry FIFO buffering processed results ahead of the valid/ready output.
module drain_skid_fifo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop_i && (r_count != 2'd0);
    assign w_push = push_i && ((r_count != 2'd2) || w_pop);

    // Storage, pointers and occupancy; push and pop together keep the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;
    assign empty_o = (r_count == 2'd0);
    assign full_o  = (r_count == 2'd2);

endmodule

// File: rtl/output_drain.sv
// Drains accumulation BRAM words, post-processes them and streams them out.
module output_drain
    import output_drain_pkg::*;
(
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic        [BRAM_ADDR_WIDTH-1:0] base_addr_i,
    input  logic        [BRAM_ADDR_WIDTH:0]   count_i,
    input  logic        [SHIFT_WIDTH-1:0]     shift_i,
    input  logic                              relu_en_i,
    input  logic                              clear_en_i,
    input  logic signed [AW_D-1:0]            bram_data_i,
    output logic        [BRAM_ADDR_WIDTH-1:0] bram_addr_o,
    output logic        [BRAM_ADDR_WIDTH-1:0] bram_clr_addr_o,
    output logic                              bram_clr_wr_en_o,
    output logic signed [OUT_WIDTH-1:0]       data_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic                              busy_o,
    output logic                              done_o
);

    drain_state_t               r_state;
    logic [BRAM_ADDR_WIDTH-1:0] r_rd_ptr;
    logic [BRAM_ADDR_WIDTH:0]   r_remaining;
    logic [SHIFT_WIDTH-1:0]     r_shift;
    logic                       r_relu;
    logic                       r_clear_en;
    logic                       r_inflight;
    logic [BRAM_ADDR_WIDTH-1:0] r_addr_hold;
    logic [BRAM_ADDR_WIDTH-1:0] r_clr_addr;
    logic                       r_clr_wr_en;
    logic                       r_busy;
    logic                       r_done;

    logic [1:0]                 w_fifo_count;
    logic                       w_fifo_empty;
    logic                       w_fifo_full;
    logic [OUT_WIDTH-1:0]       w_fifo_data;
    logic [OUT_WIDTH-1:0]       w_result;
    logic                       w_pop;
    logic [2:0]                 w_occupancy;
    logic                       w_issue;

    assign w_pop = !w_fifo_empty && ready_i;

    // Slots committed after this cycle; counting the pop keeps 1 word/cycle streaming.
    assign w_occupancy = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);

    assign w_issue = (r_state == DRAIN) && (r_remaining != '0) &&
                     (w_occupancy < 3'd2) && (!w_fifo_full || w_pop);

    assign w_result = round_sat(bram_data_i, r_shift, r_relu);

    drain_skid_fifo #(
        .WIDTH (OUT_WIDTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (r_inflight),
        .data_i  (w_result),
        .pop_i   (ready_i),
        .data_o  (w_fifo_data),
        .count_o (w_fifo_count),
        .empty_o (w_fifo_empty),
        .full_o  (w_fifo_full)
    );

    // Sequencing FSM: configuration capture, read pointer/count and busy/done flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_rd_ptr    <= '0;
            r_remaining <= '0;
            r_shift     <= '0;
            r_relu      <= 1'b0;
            r_clear_en  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_rd_ptr    <= base_addr_i;
                        r_remaining <= count_i;
                        r_shift     <= shift_i;
                        r_relu      <= relu_en_i;
                        r_clear_en  <= clear_en_i;
                        if (count_i == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= DRAIN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_issue) begin
                        r_rd_ptr    <= r_rd_ptr + BRAM_ADDR_WIDTH'(1);
                        r_remaining <= r_remaining - (BRAM_ADDR_WIDTH + 1)'(1);
                        if (r_remaining == (BRAM_ADDR_WIDTH + 1)'(1)) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (!r_inflight && w_fifo_empty) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Read-in-flight tracking, held read address and clear-on-read write strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inflight  <= 1'b0;
            r_addr_hold <= '0;
            r_clr_addr  <= '0;
            r_clr_wr_en <= 1'b0;
        end else begin
            r_inflight  <= w_issue;
            r_clr_wr_en <= w_issue && r_clear_en;
            if (w_issue) begin
                r_addr_hold <= r_rd_ptr;
                r_clr_addr  <= r_rd_ptr;
            end
        end
    end

    assign bram_addr_o      = w_issue ? r_rd_ptr : r_addr_hold;
    assign bram_clr_addr_o  = r_clr_addr;
    assign bram_clr_wr_en_o = r_clr_wr_en;
    assign data_o           = w_fifo_data;
    assign valid_o          = !w_fifo_empty;
    assign busy_o           = r_busy;
    assign done_o           = r_done;

endmodule

// File: tb/tb_output_drain.sv
// Directed self-checking bench for output_drain with a behavioural BRAM.
module tb_output_drain;
    import output_drain_pkg::*;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               start_i;
    logic [10:0]        base_addr_i;
    logic [11:0]        count_i;
    logic [3:0]         shift_i;
    logic               relu_en_i;
    logic               clear_en_i;
    logic signed [15:0] bram_data_i;
    logic [10:0]        bram_addr_o;
    logic [10:0]        bram_clr_addr_o;
    logic               bram_clr_wr_en_o;
    logic signed [7:0]  data_o;
    logic               valid_o;
    logic               ready_i;
    logic               busy_o;
    logic               done_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    output_drain dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .base_addr_i      (base_addr_i),
        .count_i          (count_i),
        .shift_i          (shift_i),
        .relu_en_i        (relu_en_i),
        .clear_en_i       (clear_en_i),
        .bram_data_i      (bram_data_i),
        .bram_addr_o      (bram_addr_o),
        .bram_clr_addr_o  (bram_clr_addr_o),
        .bram_clr_wr_en_o (bram_clr_wr_en_o),
        .data_o           (data_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    // Behavioural BRAM: one-cycle read, port-B zero write, bench preload port.
    logic [15:0] mem [0:2047];
    logic        poke_en = 1'b0;
    logic [10:0] poke_addr = '0;
    logic [15:0] poke_data = '0;
    always @(posedge clk_i) begin
        bram_data_i <= mem[bram_addr_o];
        if (bram_clr_wr_en_o) mem[bram_clr_addr_o] <= '0;
        if (poke_en) mem[poke_addr] <= poke_data;
    end

    // Transfer, clear-write and done monitor.
    logic [7:0]  got [$];
    logic [10:0] clr_q [$];
    int          done_cnt = 0;
    always @(posedge clk_i) begin
        if (!rst_i) begin
            if (valid_o && ready_i) got.push_back(data_o);
            if (bram_clr_wr_en_o) clr_q.push_back(bram_clr_addr_o);
            if (done_o) done_cnt = done_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic poke(input logic [10:0] a, input logic [15:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        tick();
        poke_en   = 1'b0;
    endtask

    task automatic start(input logic [10:0] b, input logic [11:0] c, input logic [3:0] s,
                         input logic r, input logic cl);
        base_addr_i = b;
        count_i     = c;
        shift_i     = s;
        relu_en_i   = r;
        clear_en_i  = cl;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int n = 0;
        while (done_cnt == d0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_done: done_o not seen within 200 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; ready_i = 1'b1;
        base_addr_i = '0; count_i = '0; shift_i = '0; relu_en_i = 1'b0; clear_en_i = 1'b0;
        repeat (3) tick();
        checks++;
        if ({valid_o, busy_o, done_o, bram_clr_wr_en_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {valid_o, busy_o, done_o, bram_clr_wr_en_o});
        end
        checks++;
        if (data_o !== 8'sd0) begin
            errors++;
            $display("FAIL reset_data: got %h want 00", data_o);
        end
        checks++;
        if ({bram_addr_o, bram_clr_addr_o} !== 22'd0) begin
            errors++;
            $display("FAIL reset_addr: got %h/%h want 0/0", bram_addr_o, bram_clr_addr_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] want [4] = '{8'd1, 8'd3, 8'hFF, 8'd127};
        int g0, d0;
        poke(11'd10, 16'h0100); poke(11'd11, 16'h0280);
        poke(11'd12, 16'hFF00); poke(11'd13, 16'h7FFF);
        g0 = got.size(); d0 = done_cnt;
        start(11'd10, 12'd4, 4'd8, 1'b0, 1'b0);
        checks++;
        if ({busy_o, valid_o} !== 2'b10) begin
            errors++;
            $display("FAIL basic_busy: busy/valid got %b want 10", {busy_o, valid_o});
        end
        tick();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency: valid_o got %b want 0 one cycle after start", valid_o);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (valid_o !== 1'b1 || data_o !== want[i]) begin
                errors++;
                $display("FAIL basic_word%0d: valid=%b data=%h want valid=1 data=%h", i, valid_o, data_o, want[i]);
            end
        end
        wait_done(d0, "basic");
        repeat (3) tick();
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0);
        end
        checks++;
        if (got.size() - g0 !== 4 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_transfers: got %0d busy=%b want 4 busy=0", got.size() - g0, busy_o);
        end
    endtask

    task automatic test_relu();
        int g0, d0;
        logic [7:0] v;
        poke(11'd0, 16'h8000);
        g0 = got.size(); d0 = done_cnt;
        start(11'd0, 12'd1, 4'd0, 1'b1, 1'b0);
        wait_done(d0, "relu_on");
        v = (got.size() > g0) ? got[g0] : 8'hxx;
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL relu_on: got %h want 00", v);
        end
        d0 = done_cnt;
        start(11'd0, 12'd1, 4'd0, 1'b0, 1'b0);
        wait_done(d0, "relu_off");
        v = (got.size() > g0 + 1) ? got[g0 + 1] : 8'hxx;
        checks++;
        if (v !== 8'h80) begin
            errors++;
            $display("FAIL relu_off_sat: got %h want 80", v);
        end
    endtask

    task automatic test_backpressure();
        int g0, d0;
        logic prev_stall;
        logic [7:0] prev_data, v;
        for (int i = 0; i < 6; i++) poke(11'(100 + i), 16'(17 * (i + 1)));
        g0 = got.size(); d0 = done_cnt;
        start(11'd100, 12'd6, 4'd0, 1'b0, 1'b0);
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 120 && done_cnt == d0; cyc++) begin
            if (prev_stall) begin
                checks++;
                if (valid_o !== 1'b1 || data_o !== prev_data) begin
                    errors++;
                    $display("FAIL bp_stable: valid=%b data=%h want valid=1 data=%h", valid_o, data_o, prev_data);
                end
            end
            ready_i    = (cyc % 3 == 0);
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
            tick();
        end
        ready_i = 1'b1;
        checks++;
        if (done_cnt == d0 || got.size() - g0 !== 6) begin
            errors++;
            $display("FAIL bp_count: transfers=%0d done=%0d want 6 and 1", got.size() - g0, done_cnt - d0);
        end
        for (int i = 0; i < 6; i++) begin
            v = (got.size() > g0 + i) ? got[g0 + i] : 8'hxx;
            checks++;
            if (v !== 8'(17 * (i + 1))) begin
                errors++;
                $display("FAIL bp_word%0d: got %h want %h", i, v, 8'(17 * (i + 1)));
            end
        end
    endtask

    task automatic test_wrap_clear();
        logic [10:0] addrs [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        int g0, d0, c0;
        logic [7:0]  v;
        logic [10:0] a;
        for (int i = 0; i < 4; i++) poke(addrs[i], 16'(256 * (i + 1)));
        g0 = got.size(); d0 = done_cnt; c0 = clr_q.size();
        start(11'h7FE, 12'd4, 4'd8, 1'b0, 1'b1);
        wait_done(d0, "wrap");
        checks++;
        if (clr_q.size() - c0 !== 4) begin
            errors++;
            $display("FAIL wrap_clr_count: got %0d want 4", clr_q.size() - c0);
        end
        for (int i = 0; i < 4; i++) begin
            v = (got.size() > g0 + i) ? got[g0 + i] : 8'hxx;
            a = (clr_q.size() > c0 + i) ? clr_q[c0 + i] : 11'hxxx;
            checks++;
            if (v !== 8'(i + 1) || a !== addrs[i]) begin
                errors++;
                $display("FAIL wrap_word%0d: data=%h clr=%h want data=%h clr=%h", i, v, a, 8'(i + 1), addrs[i]);
            end
        end
        checks++;
        if ((mem[11'h7FE] | mem[11'h7FF] | mem[11'h000] | mem[11'h001]) !== 16'h0) begin
            errors++;
            $display("FAIL wrap_mem_cleared: locations not zero");
        end
        g0 = got.size(); d0 = done_cnt;
        start(11'h7FE, 12'd4, 4'd0, 1'b0, 1'b0);
        wait_done(d0, "redrain");
        for (int i = 0; i < 4; i++) begin
            v = (got.size() > g0 + i) ? got[g0 + i] : 8'hxx;
            checks++;
            if (v !== 8'h00) begin
                errors++;
                $display("FAIL redrain_word%0d: got %h want 00", i, v);
            end
        end
    endtask

    task automatic test_zero_count();
        int g0, c0;
        logic [10:0] a0;
        a0 = bram_addr_o; g0 = got.size(); c0 = clr_q.size();
        start(11'd5, 12'd0, 4'd0, 1'b0, 1'b1);
        checks++;
        if ({done_o, valid_o, busy_o} !== 3'b100) begin
            errors++;
            $display("FAIL zero_done: done/valid/busy got %b want 100", {done_o, valid_o, busy_o});
        end
        tick();
        checks++;
        if (done_o !== 1'b0 || bram_addr_o !== a0) begin
            errors++;
            $display("FAIL zero_after: done=%b addr=%h want done=0 addr=%h", done_o, bram_addr_o, a0);
        end
        checks++;
        if (got.size() !== g0 || clr_q.size() !== c0) begin
            errors++;
            $display("FAIL zero_activity: transfers=%0d clears=%0d want 0 and 0", got.size() - g0, clr_q.size() - c0);
        end
    endtask

    task automatic test_ignored_start();
        int g0, d0;
        logic [7:0] v;
        for (int i = 0; i < 3; i++) poke(11'(200 + i), 16'(5 + i));
        g0 = got.size(); d0 = done_cnt;
        start(11'd200, 12'd3, 4'd0, 1'b0, 1'b0);
        tick();
        base_addr_i = 11'd300; count_i = 12'd5; shift_i = 4'd3;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(d0, "ignored");
        repeat (5) tick();
        checks++;
        if (got.size() - g0 !== 3 || done_cnt - d0 !== 1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL ignored_effect: transfers=%0d dones=%0d busy=%b want 3 1 0", got.size() - g0, done_cnt - d0, busy_o);
        end
        for (int i = 0; i < 3; i++) begin
            v = (got.size() > g0 + i) ? got[g0 + i] : 8'hxx;
            checks++;
            if (v !== 8'(5 + i)) begin
                errors++;
                $display("FAIL ignored_word%0d: got %h want %h", i, v, 8'(5 + i));
            end
        end
    endtask

    task automatic test_mid_reset();
        int g0, d0, c0, n;
        for (int i = 0; i < 8; i++) poke(11'(400 + i), 16'(i + 1));
        g0 = got.size(); d0 = done_cnt;
        start(11'd400, 12'd8, 4'd0, 1'b0, 1'b1);
        n = 0;
        while (got.size() < g0 + 2 && n < 50) begin
            tick();
            n++;
        end
        rst_i = 1'b1;
        c0 = clr_q.size();
        tick();
        checks++;
        if ({valid_o, busy_o, done_o, bram_clr_wr_en_o} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_flags: valid/busy/done/clr got %b want 0000", {valid_o, busy_o, done_o, bram_clr_wr_en_o});
        end
        rst_i = 1'b0;
        repeat (6) tick();
        checks++;
        if (done_cnt !== d0 || clr_q.size() !== c0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: dones=%0d clears=%0d valid=%b want 0 0 0", done_cnt - d0, clr_q.size() - c0, valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_backpressure();
        test_wrap_clear();
        test_zero_count();
        test_ignored_start();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
